// File: rtl/mds_seq_ctrl.sv
// Serial Twofish MDS matrix multiplier: one GF(2^8) multiplier is time-shared
// over 16 cycles to build the four result rows, then the result is handshaked out.

module gf_multi (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  logic [7:0] sh;
  logic [7:0] acc;

  // Shift-and-add multiply, reducing by x^8 + x^6 + x^5 + x^3 + 1 whenever the shifted operand overflows.
  always_comb begin
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[7] ? ({sh[6:0], 1'b0} ^ 8'h69) : {sh[6:0], 1'b0};
    end
    p = acc;
  end

endmodule

module mds_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  y0,
  input  logic [7:0]  y1,
  input  logic [7:0]  y2,
  input  logic [7:0]  y3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [3:0]       k;
  logic [3:0][7:0]  y_reg;
  logic [3:0][7:0]  acc;
  logic [7:0]       coef;
  logic [7:0]       prod;

  // k[3:2] selects the matrix row, k[1:0] the column and the captured byte.
  always_comb begin
    coef = 8'h00;
    case (k)
      4'd0:  coef = 8'h01;
      4'd1:  coef = 8'hEF;
      4'd2:  coef = 8'h5B;
      4'd3:  coef = 8'h5B;
      4'd4:  coef = 8'h5B;
      4'd5:  coef = 8'hEF;
      4'd6:  coef = 8'hEF;
      4'd7:  coef = 8'h01;
      4'd8:  coef = 8'hEF;
      4'd9:  coef = 8'h5B;
      4'd10: coef = 8'h01;
      4'd11: coef = 8'hEF;
      4'd12: coef = 8'hEF;
      4'd13: coef = 8'h01;
      4'd14: coef = 8'hEF;
      4'd15: coef = 8'h5B;
      default: coef = 8'h00;
    endcase
  end

  gf_multi u_gf (
    .a (coef),
    .b (y_reg[k[1:0]]),
    .p (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = MUL;
      end
      MUL: begin
        if (k == 4'd15) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Accumulators are only cleared on capture so the last result stays visible in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k     <= 4'd0;
      y_reg <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            y_reg <= {y3, y2, y1, y0};
            acc   <= '0;
            k     <= 4'd0;
          end
        end
        MUL: begin
          acc[k[3:2]] <= acc[k[3:2]] ^ prod;
          k           <= k + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign out  = {acc[0], acc[1], acc[2], acc[3]};
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mds_seq_ctrl.sv
// Self-checking bench for mds_seq_ctrl: known vectors, backpressure, mid-run reset
// and 1000 random back-to-back words against a polynomial-arithmetic MDS model.

module tb_mds_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  y0 = 8'h00, y1 = 8'h00, y2 = 8'h00, y3 = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] mat [4][4] = '{'{8'h01, 8'hEF, 8'h5B, 8'h5B},
                             '{8'h5B, 8'hEF, 8'hEF, 8'h01},
                             '{8'hEF, 8'h5B, 8'h01, 8'hEF},
                             '{8'hEF, 8'h01, 8'hEF, 8'h5B}};

  mds_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Carry-less product followed by long division by the field polynomial 0x169.
  function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int d = 14; d >= 8; d--)
      if (p[d]) p = p ^ (16'h169 << (d - 8));
    return p[7:0];
  endfunction

  // w packs {y0, y1, y2, y3}; result packs {row0, row1, row2, row3}.
  function automatic logic [31:0] mds_ref(input logic [31:0] w);
    logic [7:0]  yv [4];
    logic [7:0]  row;
    logic [31:0] r;
    for (int j = 0; j < 4; j++) yv[j] = w[31 - 8*j -: 8];
    r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      row = 8'h00;
      for (int j = 0; j < 4; j++) row = row ^ gf_ref(mat[i][j], yv[j]);
      r[31 - 8*i -: 8] = row;
    end
    return r;
  endfunction

  // Presents one word at a negedge where in_ready is high, scrambles the inputs
  // during the run, and returns at the first negedge showing out_valid.
  task automatic do_op(input logic [31:0] w, output logic [31:0] res, output int edges,
                       output int vcyc, output bit timed_out);
    int guard;
    guard = 0;
    timed_out = 1'b0;
    res = 32'h0;
    edges = -1;
    vcyc = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      timed_out = 1'b1;
      return;
    end
    {y0, y1, y2, y3} = w;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 100) begin
      {y0, y1, y2, y3} = $urandom;
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      edges++;
    end
    in_valid  = 1'b0;
    timed_out = !out_valid;
    res  = out;
    vcyc = cyc;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (out !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_out: got %h want 00000000", out); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_idle: in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] words [4] = '{32'h01000000, 32'h00010000, 32'h00000000, 32'h02000000};
    logic [31:0] exp   [4] = '{32'h015BEFEF, 32'hEFEF5B01, 32'h00000000, 32'h02B6B7B7};
    logic [31:0] res;
    int edges, vcyc;
    bit to;
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      do_op(words[t], res, edges, vcyc, to);
      n_checks++;
      if (to) begin
        n_fail++;
        $display("[TB] FAIL vector_timeout[%0d]: got no out_valid want out_valid", t);
        continue;
      end
      if (res !== exp[t]) begin n_fail++; $display("[TB] FAIL vector_out[%0d]: got %h want %h", t, res, exp[t]); end
      n_checks++;
      if (edges !== 16) begin n_fail++; $display("[TB] FAIL vector_latency[%0d]: got %0d edges want 16", t, edges); end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL vector_valid_pulse[%0d]: got %b want 0", t, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w, res, expv;
    int edges, vcyc, bad;
    bit to;
    out_ready = 1'b0;
    w = $urandom;
    expv = mds_ref(w);
    do_op(w, res, edges, vcyc, to);
    n_checks++;
    if (to || res !== expv) begin n_fail++; $display("[TB] FAIL bp_result: got %h want %h", res, expv); end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      {y0, y1, y2, y3} = $urandom;
      in_valid = (c == 4);
      @(negedge clk);
      if (out_valid !== 1'b1 || out !== expv || in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("[TB] FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_release: got valid=%b ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (out !== expv || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_out_retained: got %h busy=%b want %h busy=0", out, busy, expv);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w, res, expv;
    int edges, vcyc, seen;
    bit to;
    out_ready = 1'b1;
    while (!in_ready) @(negedge clk);
    {y0, y1, y2, y3} = $urandom;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (out !== 32'h0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_reset: got out=%h valid=%b busy=%b ready=%b want 00000000/0/0/1",
               out, out_valid, busy, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("[TB] FAIL mid_reset_no_result: got %0d active cycles want 0", seen); end
    w = $urandom;
    expv = mds_ref(w);
    do_op(w, res, edges, vcyc, to);
    n_checks++;
    if (to || res !== expv) begin n_fail++; $display("[TB] FAIL mid_reset_fresh: got %h want %h", res, expv); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w, res, expv;
    int edges, vcyc, prev_vcyc;
    bit to;
    out_ready = 1'b1;
    prev_vcyc = -1;
    for (int n = 0; n < 1000; n++) begin
      w = $urandom;
      expv = mds_ref(w);
      do_op(w, res, edges, vcyc, to);
      n_checks++;
      if (to) begin
        n_fail++;
        $display("[TB] FAIL b2b_timeout[%0d]: got no out_valid want out_valid", n);
        break;
      end
      if (res !== expv) begin n_fail++; $display("[TB] FAIL b2b_out[%0d]: got %h want %h (in %h)", n, res, expv, w); end
      if (prev_vcyc >= 0) begin
        n_checks++;
        if (vcyc - prev_vcyc != 18) begin
          n_fail++;
          $display("[TB] FAIL b2b_spacing[%0d]: got %0d cycles want 18", n, vcyc - prev_vcyc);
        end
      end
      prev_vcyc = vcyc;
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
